// File: rtl/joypad_port.sv
// joypad_port: NES controller ports at $4016/$4017.
// Implements the strobe latch, the per-pad 8-bit shift registers and the
// serial read-out that software polls one bit per access.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pad1_state, pad2_state        parallel button state (1 = pressed)
//   cpu_addr, cpu_data_in         CPU bus address / write data
//   cpu_write_en, cpu_read_en     level strobes; only the rising edge is an access
//   read_data, read_valid         registered read result and its one-cycle pulse
//   strobe_out                    current strobe latch
//   pad1_cnt                      pad-1 reads since strobe fell, saturating at 8
module joypad_port #(
    parameter logic [15:0] ADDR_PAD1   = 16'h4016,
    parameter logic [15:0] ADDR_PAD2   = 16'h4017,
    parameter logic [7:0]  OPEN_BUS    = 8'h40,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pad1_state,
    input  logic [7:0]  pad2_state,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_write_en,
    input  logic        cpu_read_en,
    output logic [7:0]  read_data,
    output logic        read_valid,
    output logic        strobe_out,
    output logic [3:0]  pad1_cnt
);

    localparam int unsigned NPADS   = 2;
    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(8);

    // Synchroniser chains, index 0 is the input-side stage
    logic [SYNC_STAGES-1:0][7:0] sync1_q, sync1_d;
    logic [SYNC_STAGES-1:0][7:0] sync2_q, sync2_d;

    logic                        wr_en_q, wr_en_d;
    logic                        rd_en_q, rd_en_d;
    logic                        strobe_q, strobe_d;
    logic [NPADS-1:0][7:0]       sr_q, sr_d;
    logic [NPADS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]                  read_data_q, read_data_d;
    logic                        read_valid_q, read_valid_d;

    logic             wr_rise_c, rd_rise_c;
    logic             wr_pad1_c, set_strobe_c, reload_c;
    logic [NPADS-1:0] rd_pad_c;
    logic [NPADS-1:0][7:0] sync_c;
    logic             unused_data_c;

    // Only bit 0 of the written byte is meaningful
    assign unused_data_c = ^cpu_data_in[7:1];

    // Synchroniser shift
    always_comb begin
        sync1_d = sync1_q;
        sync2_d = sync2_q;
        sync1_d[0] = pad1_state;
        sync2_d[0] = pad2_state;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync1_d[i] = sync1_q[i-1];
            sync2_d[i] = sync2_q[i-1];
        end
    end

    // Access decode: one event per enable rising edge; a write suppresses a read
    always_comb begin
        wr_en_d      = cpu_write_en;
        rd_en_d      = cpu_read_en;
        wr_rise_c    = cpu_write_en & ~wr_en_q;
        rd_rise_c    = cpu_read_en & ~rd_en_q & ~wr_rise_c;
        wr_pad1_c    = wr_rise_c && (cpu_addr == ADDR_PAD1);
        set_strobe_c = wr_pad1_c & cpu_data_in[0];
        // Continuous reload while strobe is high, but not on the cycle it is written low
        reload_c     = strobe_q & ~wr_pad1_c;
        rd_pad_c[0]  = rd_rise_c && (cpu_addr == ADDR_PAD1);
        rd_pad_c[1]  = rd_rise_c && (cpu_addr == ADDR_PAD2);
        sync_c[0]    = sync1_q[SYNC_STAGES-1];
        sync_c[1]    = sync2_q[SYNC_STAGES-1];
    end

    // Strobe, shift registers, counters and read port
    always_comb begin
        strobe_d     = strobe_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;

        if (wr_pad1_c) begin
            strobe_d = cpu_data_in[0];
        end

        for (int n = 0; n < int'(NPADS); n++) begin
            if (set_strobe_c || reload_c) begin
                sr_d[n]  = sync_c[n];
                cnt_d[n] = '0;
            end else if (rd_pad_c[n]) begin
                // Shift in 1s so reads past the eighth return 1
                sr_d[n]  = {1'b1, sr_q[n][7:1]};
                cnt_d[n] = (cnt_q[n] == CNT_MAX) ? CNT_MAX : cnt_q[n] + CNT_W'(1);
            end
        end

        // Read returns the pre-update LSB of the addressed pad
        if (rd_pad_c[0]) begin
            read_data_d  = OPEN_BUS | {7'b0, sr_q[0][0]};
            read_valid_d = 1'b1;
        end else if (rd_pad_c[1]) begin
            read_data_d  = OPEN_BUS | {7'b0, sr_q[1][0]};
            read_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            strobe_q     <= 1'b0;
            sr_q         <= '0;
            cnt_q        <= '0;
            read_data_q  <= 8'h00;
            read_valid_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            strobe_q     <= strobe_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign strobe_out = strobe_q;
    assign pad1_cnt   = cnt_q[0];

endmodule
